// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/DIV unit with HI/LO registers, MTHI/MTLO and busy/done handshake.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU only flag o_div0.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div0,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     ma_q, ma_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 sgn;
  logic [WIDTH-1:0]     ma_in, mb_in;
  logic [WIDTH:0]       s;
  logic [2*WIDTH-1:0]   p;
  logic                 last;
`ifdef MDU_DIV_EN
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 rneg_q, rneg_d;
  logic                 zero_q, zero_d;
  logic                 div_q, div_d;
  logic [WIDTH:0]       sh, t;
`endif
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_div0 = div0_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    mb_d    = mb_q;
    a_d     = a_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    div_d   = div_q;
    sh      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    t       = sh - {1'b0, mb_q};
`endif
    sgn   = ~i_op[0];
    ma_in = (sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    mb_in = (sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    p     = neg_q ? -acc_q : acc_q;
    last  = cnt_q == CNT_W'(WIDTH - 1);
    case (state_q)
      S_IDLE: if (i_start) begin
        div0_d = 1'b0;
        case (i_op)
          3'd0, 3'd1: begin
            ma_d    = ma_in;
            acc_d   = {{WIDTH{1'b0}}, mb_in};
            neg_d   = sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_MUL;
`ifdef MDU_DIV_EN
            div_d   = 1'b0;
`endif
          end
          3'd2, 3'd3: begin
`ifdef MDU_DIV_EN
            acc_d   = {{WIDTH{1'b0}}, ma_in};
            mb_d    = mb_in;
            a_d     = i_a;
            neg_d   = sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            rneg_d  = sgn & i_a[WIDTH-1];
            zero_d  = i_b == '0;
            div_d   = 1'b1;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_DIV;
`else
            done_d  = 1'b1;
            div0_d  = 1'b1;
`endif
          end
          3'd4: begin
            hi_d   = i_a;
            done_d = 1'b1;
          end
          3'd5: begin
            lo_d   = i_a;
            done_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        acc_d   = {s, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? S_FIX : S_MUL;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        // restoring step: keep the shifted remainder when the trial subtract goes negative
        acc_d   = {t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0], acc_q[WIDTH-2:0], ~t[WIDTH]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? S_FIX : S_DIV;
      end
`endif
      S_FIX: begin
        hi_d = p[2*WIDTH-1:WIDTH];
        lo_d = p[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (div_q) begin
          hi_d   = zero_q ? a_q : (rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]);
          lo_d   = zero_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          div0_d = zero_q;
        end
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      mb_q    <= '0;
      a_q     <= '0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      mb_q    <= mb_d;
      a_q     <= a_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      div_q   <= div_d;
`endif
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit (WIDTH=32); DIV expectations follow MDU_DIV_EN.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_busy, o_done, o_div0;
  logic [31:0] o_hi, o_lo;
  int total = 0;
  int bad = 0;
  int pulses;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_div0(o_div0), .o_hi(o_hi), .o_lo(o_lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // called at the negedge of cycle 0; returns at the negedge of cycle 1
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op = op;
    i_a = a;
    i_b = b;
    @(negedge clk);
    i_start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, o_done}, 32'd1);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_div0", {31'd0, o_div0}, 32'd0);
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    // MULTU max*max with exact cycle timing
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pulses = 0;
    for (int c = 1; c <= 33; c++) begin
      if (!o_busy) pulses++;
      if (o_done) pulses++;
      if (c < 33) @(negedge clk);
    end
    chk("t1_busy_window", pulses, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, o_done}, 32'd1);
    chk("t1_busy_end", {31'd0, o_busy}, 32'd0);
    chk("t1_hi", o_hi, 32'hFFFF_FFFE);
    chk("t1_lo", o_lo, 32'h0000_0001);
    // start in the done cycle is accepted: MTHI
    issue(3'd4, 32'h0000_1234, 32'd0);
    chk("mthi_done", {31'd0, o_done}, 32'd1);
    chk("mthi_hi", o_hi, 32'h0000_1234);
    chk("mthi_lo", o_lo, 32'h0000_0001);
    @(negedge clk);
    chk("mthi_done_once", {31'd0, o_done}, 32'd0);
    // MULT -3*5
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done("t2_wait");
    chk("t2_hi", o_hi, 32'hFFFF_FFFF);
    chk("t2_lo", o_lo, 32'hFFFF_FFF1);
    @(negedge clk);
    // MULT -1*-1
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("m11_wait");
    chk("m11_hi", o_hi, 32'h0);
    chk("m11_lo", o_lo, 32'h1);
    @(negedge clk);
    issue(3'd5, 32'hFFFF_FFF1, 32'd0);
    issue(3'd4, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_DIV_EN
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("d1_wait");
    chk("d1_lo", o_lo, 32'hFFFF_FFFD);
    chk("d1_hi", o_hi, 32'hFFFF_FFFF);
    chk("d1_div0", {31'd0, o_div0}, 32'd0);
    @(negedge clk);
    issue(3'd2, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done("d2_wait");
    chk("d2_lo", o_lo, 32'hFFFF_FFFD);
    chk("d2_hi", o_hi, 32'h0000_0001);
    @(negedge clk);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("dmin_wait");
    chk("dmin_lo", o_lo, 32'h8000_0000);
    chk("dmin_hi", o_hi, 32'h0);
    @(negedge clk);
    issue(3'd3, 32'd100, 32'd7);
    wait_done("du_wait");
    chk("du_lo", o_lo, 32'd14);
    chk("du_hi", o_hi, 32'd2);
    @(negedge clk);
    issue(3'd3, 32'd7, 32'd0);
    wait_done("dz_wait");
    chk("dz_div0", {31'd0, o_div0}, 32'd1);
    chk("dz_hi", o_hi, 32'h0000_0007);
    chk("dz_lo", o_lo, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("dz_div0_held", {31'd0, o_div0}, 32'd1);
    issue(3'd5, 32'h0000_0055, 32'd0);
    chk("mtlo_done", {31'd0, o_done}, 32'd1);
    chk("mtlo_div0", {31'd0, o_div0}, 32'd0);
    chk("mtlo_lo", o_lo, 32'h0000_0055);
    chk("mtlo_hi", o_hi, 32'h0000_0007);
`else
    issue(3'd3, 32'd9, 32'd3);
    chk("nd_done", {31'd0, o_done}, 32'd1);
    chk("nd_div0", {31'd0, o_div0}, 32'd1);
    chk("nd_busy", {31'd0, o_busy}, 32'd0);
    chk("nd_hi", o_hi, 32'hFFFF_FFFF);
    chk("nd_lo", o_lo, 32'hFFFF_FFF1);
    issue(3'd5, 32'h0000_0055, 32'd0);
    chk("mtlo_div0", {31'd0, o_div0}, 32'd0);
    chk("mtlo_lo", o_lo, 32'h0000_0055);
    chk("mtlo_hi", o_hi, 32'hFFFF_FFFF);
`endif
    @(negedge clk);
    // MULTU 3*4 with an ignored start and operand changes while busy
    issue(3'd1, 32'd3, 32'd4);
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      if (o_done) pulses++;
      if (c == 34) begin
        chk("t5_done_c34", {31'd0, o_done}, 32'd1);
        chk("t5_hi", o_hi, 32'h0);
        chk("t5_lo", o_lo, 32'h0000_000C);
      end
      i_start = (c == 5);
      i_op = 3'd3;
      i_a = 32'd99;
      i_b = (c == 5) ? 32'd0 : 32'd77;
      @(negedge clk);
    end
    i_start = 1'b0;
    chk("t5_pulses", pulses, 32'd1);
    chk("t5_div0", {31'd0, o_div0}, 32'd0);
    // reserved op: no state change, no done
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_done || o_busy) pulses++;
      @(negedge clk);
    end
    chk("rsv_quiet", pulses, 32'd0);
    chk("rsv_hi", o_hi, 32'h0);
    chk("rsv_lo", o_lo, 32'h0000_000C);
    // reset mid-operation
    issue(3'd0, 32'd1000, 32'd1000);
    for (int c = 1; c < 10; c++) @(negedge clk);
    chk("t6_busy_pre", {31'd0, o_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy", {31'd0, o_busy}, 32'd0);
    chk("t6_hi", o_hi, 32'h0);
    chk("t6_lo", o_lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done || o_busy) pulses++;
      @(negedge clk);
    end
    chk("t6_no_done", pulses, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
